// File: rtl/supernova_pkg.sv
// Shared widths and rename payload types for the supernova rename stage.
package supernova_pkg;

   localparam int unsigned FETCH_WIDTH    = 2;
   localparam int unsigned COMMIT_WIDTH   = 2;
   localparam int unsigned NUM_ARCH_GPRS  = 32;
   localparam int unsigned NUM_PHYS_GPRS  = 64;
   localparam int unsigned ARCH_REG_WIDTH = $clog2(NUM_ARCH_GPRS);
   localparam int unsigned GPR_TAG_WIDTH  = $clog2(NUM_PHYS_GPRS);

   typedef logic [ARCH_REG_WIDTH-1:0] areg_t;
   typedef logic [GPR_TAG_WIDTH-1:0]  ptag_t;

   // One renamed micro-op as held in the output register
   typedef struct packed {
      ptag_t prs1;
      ptag_t prs2;
      ptag_t prd;
      ptag_t old_prd;
   } ren_uop_t;

endpackage

// File: rtl/supernova_rename_bypass.sv
// Intra-group dependency resolution: sources and old destination tags see
// the newest earlier allocating lane of the same group before the RAT.
module supernova_rename_bypass
   import supernova_pkg::*;
(
   input  areg_t [FETCH_WIDTH-1:0] rs1_in,
   input  areg_t [FETCH_WIDTH-1:0] rs2_in,
   input  areg_t [FETCH_WIDTH-1:0] rd_in,
   input  logic  [FETCH_WIDTH-1:0] alloc_in,
   input  ptag_t [FETCH_WIDTH-1:0] alloc_tag_in,
   input  ptag_t [FETCH_WIDTH-1:0] rat_rs1_in,
   input  ptag_t [FETCH_WIDTH-1:0] rat_rs2_in,
   input  ptag_t [FETCH_WIDTH-1:0] rat_rd_in,
   output ptag_t [FETCH_WIDTH-1:0] prs1_c,
   output ptag_t [FETCH_WIDTH-1:0] prs2_c,
   output ptag_t [FETCH_WIDTH-1:0] old_prd_c
);

   // Ascending scan over earlier lanes so the newest producer wins
   always_comb begin
      prs1_c    = '0;
      prs2_c    = '0;
      old_prd_c = '0;
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
         prs1_c[i]    = (rs1_in[i] == '0) ? '0 : rat_rs1_in[i];
         prs2_c[i]    = (rs2_in[i] == '0) ? '0 : rat_rs2_in[i];
         old_prd_c[i] = alloc_in[i] ? rat_rd_in[i] : '0;
         for (int unsigned j = 0; j < i; j++) begin
            if (alloc_in[j] && (rd_in[j] == rs1_in[i])) prs1_c[i] = alloc_tag_in[j];
            if (alloc_in[j] && (rd_in[j] == rs2_in[i])) prs2_c[i] = alloc_tag_in[j];
            if (alloc_in[j] && alloc_in[i] && (rd_in[j] == rd_in[i]))
               old_prd_c[i] = alloc_tag_in[j];
         end
      end
   end

endmodule

// File: rtl/supernova_rename_map.sv
// Register rename map: speculative + architectural RATs, free-list allocation,
// one-cycle registered rename output. SUPERNOVA_RENAME_PERF_EN adds stall counters.
module supernova_rename_map
   import supernova_pkg::*;
#(
   parameter int HART_ID = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
`ifdef SUPERNOVA_RENAME_PERF_EN
   output logic [31:0]              perf_fl_stall_cnt_out,
   output logic [31:0]              perf_bp_stall_cnt_out,
`endif
   input  logic  [FETCH_WIDTH-1:0]  dec_valid_in,
   input  areg_t [FETCH_WIDTH-1:0]  dec_rs1_in,
   input  areg_t [FETCH_WIDTH-1:0]  dec_rs2_in,
   input  areg_t [FETCH_WIDTH-1:0]  dec_rd_in,
   input  logic  [FETCH_WIDTH-1:0]  dec_rd_wen_in,
   output logic                     dec_ready_out,
   input  ptag_t [FETCH_WIDTH-1:0]  fl_alloc_tag_in,
   input  logic                     fl_alloc_ready_in,
   output logic  [FETCH_WIDTH-1:0]  fl_alloc_consume_out,
   output logic  [FETCH_WIDTH-1:0]  ren_valid_out,
   output ptag_t [FETCH_WIDTH-1:0]  ren_prs1_out,
   output ptag_t [FETCH_WIDTH-1:0]  ren_prs2_out,
   output ptag_t [FETCH_WIDTH-1:0]  ren_prd_out,
   output ptag_t [FETCH_WIDTH-1:0]  ren_old_prd_out,
   input  logic                     ren_ready_in,
   input  logic  [COMMIT_WIDTH-1:0] commit_valid_in,
   input  areg_t [COMMIT_WIDTH-1:0] commit_rd_in,
   input  ptag_t [COMMIT_WIDTH-1:0] commit_prd_in,
   input  logic                     redirect_valid_in
);

   localparam int unsigned CNT_W = $clog2(FETCH_WIDTH + 1);

   // HART_ID only tags perf data; a negative index is meaningless
   if (HART_ID < 0) begin : g_hart_id_invalid
   end

   ptag_t    [NUM_ARCH_GPRS-1:0] spec_rat_q, spec_rat_d;
   ptag_t    [NUM_ARCH_GPRS-1:0] arch_rat_q, arch_rat_d;
   ren_uop_t [FETCH_WIDTH-1:0]   ren_q, ren_d;
   logic     [FETCH_WIDTH-1:0]   ren_valid_q, ren_valid_d;

   logic                    accept_c;
   logic [FETCH_WIDTH-1:0]  alloc_c;
   ptag_t [FETCH_WIDTH-1:0] alloc_tag_c;
   logic [CNT_W-1:0]        n_alloc_c;
   ptag_t [FETCH_WIDTH-1:0] rat_rs1_c, rat_rs2_c, rat_rd_c;
   ptag_t [FETCH_WIDTH-1:0] prs1_c, prs2_c, old_prd_c;

   assign dec_ready_out = (!(|ren_valid_q) || ren_ready_in) && fl_alloc_ready_in
                          && !redirect_valid_in;
   // A group caught by reset is dropped without touching the free list
   assign accept_c      = rst_n && (|dec_valid_in) && dec_ready_out;

   // k-th allocating lane in lane order takes the k-th free-list head tag
   always_comb begin
      alloc_c     = '0;
      alloc_tag_c = '0;
      n_alloc_c   = '0;
      rat_rs1_c   = '0;
      rat_rs2_c   = '0;
      rat_rd_c    = '0;
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
         rat_rs1_c[i] = spec_rat_q[dec_rs1_in[i]];
         rat_rs2_c[i] = spec_rat_q[dec_rs2_in[i]];
         rat_rd_c[i]  = spec_rat_q[dec_rd_in[i]];
         alloc_c[i]   = dec_valid_in[i] && dec_rd_wen_in[i] && (dec_rd_in[i] != '0);
         if (alloc_c[i]) begin
            for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
               if (n_alloc_c == CNT_W'(k)) alloc_tag_c[i] = fl_alloc_tag_in[k];
            end
            n_alloc_c = n_alloc_c + CNT_W'(1);
         end
      end
   end

   always_comb begin
      fl_alloc_consume_out = '0;
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
         fl_alloc_consume_out[i] = accept_c && (CNT_W'(i) < n_alloc_c);
      end
   end

   supernova_rename_bypass u_bypass (
      .rs1_in       (dec_rs1_in),
      .rs2_in       (dec_rs2_in),
      .rd_in        (dec_rd_in),
      .alloc_in     (alloc_c),
      .alloc_tag_in (alloc_tag_c),
      .rat_rs1_in   (rat_rs1_c),
      .rat_rs2_in   (rat_rs2_c),
      .rat_rd_in    (rat_rd_c),
      .prs1_c       (prs1_c),
      .prs2_c       (prs2_c),
      .old_prd_c    (old_prd_c)
   );

   // RAT updates and output register; later lanes overwrite earlier ones
   always_comb begin
      spec_rat_d  = spec_rat_q;
      arch_rat_d  = arch_rat_q;
      ren_valid_d = ren_valid_q;
      ren_d       = ren_q;
      for (int unsigned c = 0; c < COMMIT_WIDTH; c++) begin
         if (commit_valid_in[c] && (commit_rd_in[c] != '0))
            arch_rat_d[commit_rd_in[c]] = commit_prd_in[c];
      end
      if (redirect_valid_in) begin
         spec_rat_d  = arch_rat_d;
         ren_valid_d = '0;
      end else if (accept_c) begin
         ren_valid_d = dec_valid_in;
         for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            if (alloc_c[i]) spec_rat_d[dec_rd_in[i]] = alloc_tag_c[i];
            ren_d[i].prs1    = prs1_c[i];
            ren_d[i].prs2    = prs2_c[i];
            ren_d[i].prd     = alloc_c[i] ? alloc_tag_c[i] : '0;
            ren_d[i].old_prd = old_prd_c[i];
         end
      end else if (!(|ren_valid_q) || ren_ready_in) begin
         ren_valid_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned r = 0; r < NUM_ARCH_GPRS; r++) begin
            spec_rat_q[r] <= GPR_TAG_WIDTH'(r);
            arch_rat_q[r] <= GPR_TAG_WIDTH'(r);
         end
         ren_valid_q <= '0;
         ren_q       <= '0;
      end else begin
         spec_rat_q  <= spec_rat_d;
         arch_rat_q  <= arch_rat_d;
         ren_valid_q <= ren_valid_d;
         ren_q       <= ren_d;
      end
   end

   always_comb begin
      ren_valid_out   = ren_valid_q;
      ren_prs1_out    = '0;
      ren_prs2_out    = '0;
      ren_prd_out     = '0;
      ren_old_prd_out = '0;
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
         ren_prs1_out[i]    = ren_q[i].prs1;
         ren_prs2_out[i]    = ren_q[i].prs2;
         ren_prd_out[i]     = ren_q[i].prd;
         ren_old_prd_out[i] = ren_q[i].old_prd;
      end
   end

`ifdef SUPERNOVA_RENAME_PERF_EN
   logic [31:0] fl_cnt_q, fl_cnt_d, bp_cnt_q, bp_cnt_d;

   // Saturating stall counters
   always_comb begin
      fl_cnt_d = fl_cnt_q;
      bp_cnt_d = bp_cnt_q;
      if ((|dec_valid_in) && !fl_alloc_ready_in && (fl_cnt_q != '1))
         fl_cnt_d = fl_cnt_q + 32'd1;
      if ((|ren_valid_q) && !ren_ready_in && (bp_cnt_q != '1))
         bp_cnt_d = bp_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fl_cnt_q <= '0;
         bp_cnt_q <= '0;
      end else begin
         fl_cnt_q <= fl_cnt_d;
         bp_cnt_q <= bp_cnt_d;
      end
   end

   assign perf_fl_stall_cnt_out = fl_cnt_q;
   assign perf_bp_stall_cnt_out = bp_cnt_q;
`endif

endmodule

// File: doc/supernova_rename_map.md
SUPERNOVA_RENAME_MAP -- requirements
Module: supernova_rename_map

Interface
REQ-001 SHALL have parameter: HART_ID, 0, hart index (perf tagging only).
REQ-002 SHALL have port: clk  in  1  clock, rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: dec_valid_in  in  FETCH_WIDTH  per-lane decoded uop valid; dec_rs1_in/dec_rs2_in/dec_rd_in  in  FETCH_WIDTH x 5  arch regs; dec_rd_wen_in  in  FETCH_WIDTH  dest write.
REQ-005 SHALL have port: dec_ready_out  out  1  group accepted this cycle.
REQ-006 SHALL have ports: fl_alloc_tag_in  in  FETCH_WIDTH x GPR_TAG_WIDTH  free-list head tags; fl_alloc_ready_in  in  1  FETCH_WIDTH tags available.
REQ-007 SHALL have port: fl_alloc_consume_out  out  FETCH_WIDTH  thermometer mask of tags consumed.
REQ-008 SHALL have ports: ren_valid_out  out  FETCH_WIDTH; ren_prs1_out/ren_prs2_out/ren_prd_out/ren_old_prd_out  out  FETCH_WIDTH x GPR_TAG_WIDTH; ren_ready_in  in  1.
REQ-009 SHALL have ports: commit_valid_in  in  COMMIT_WIDTH; commit_rd_in  in  COMMIT_WIDTH x 5; commit_prd_in  in  COMMIT_WIDTH x GPR_TAG_WIDTH.
REQ-010 SHALL have port: redirect_valid_in  in  1  flush/restore.

Function
REQ-011 SHALL hold a speculative RAT and an architectural RAT, 32 entries x GPR_TAG_WIDTH each.
REQ-012 dec_ready_out SHALL equal (!any ren_valid_out || ren_ready_in) && fl_alloc_ready_in && !redirect_valid_in.
REQ-013 Group SHALL be accepted when any dec_valid_in && dec_ready_out; outputs registered, latency 1 cycle.
REQ-014 Output register SHALL hold unchanged while any ren_valid_out && !ren_ready_in.
REQ-015 Lane allocates iff valid && rd_wen && rd!=0; k-th allocating lane (k from 0, lane order) takes fl_alloc_tag_in[k].
REQ-016 fl_alloc_consume_out SHALL have low N bits set, N = allocating lanes, only in accept cycle; else 0.
REQ-017 Non-allocating lane: ren_prd_out = 0, ren_old_prd_out = 0.
REQ-018 Source x0 SHALL map to tag 0.
REQ-019 Source matching rd of an earlier allocating lane in group SHALL take the newest such lane's tag, else speculative RAT.
REQ-020 ren_old_prd_out SHALL come from newest earlier allocating lane with same rd, else speculative RAT.
REQ-021 Speculative RAT write on accept; same rd in several lanes: highest lane wins.
REQ-022 Architectural RAT write per commit lane with rd!=0; same rd: highest lane wins.
REQ-023 On redirect_valid_in: next edge speculative RAT <= architectural RAT including same-cycle commits; ren_valid_out <= 0; no accept, no consume.
REQ-024 Invalid lanes inside an accepted group SHALL produce ren_valid_out lane bit 0.

Reset
REQ-025 Both RATs SHALL reset to identity (arch r -> tag r).
REQ-026 ren_valid_out, fl_alloc_consume_out SHALL reset to 0; tag outputs 0.
REQ-027 Reset mid-group SHALL drop the group; no tags consumed.

Configuration
REQ-028 Macro SUPERNOVA_RENAME_PERF_EN SHALL add outputs perf_fl_stall_cnt_out and perf_bp_stall_cnt_out (32 bits each, saturating).
REQ-029 With macro: fl counter increments on cycles with any dec_valid_in && !fl_alloc_ready_in; bp counter on any ren_valid_out && !ren_ready_in; both reset to 0.
REQ-030 Without macro: ports and counters absent; function unchanged.

Structure
REQ-031 FETCH_WIDTH, COMMIT_WIDTH, GPR_TAG_WIDTH, NUM_ARCH_GPRS, NUM_PHYS_GPRS, rename-uop struct SHALL live in supernova_pkg.
REQ-032 Sub-module supernova_rename_bypass SHALL implement combinational intra-group source/old-tag selection (REQ-019/020).

Verification (FETCH_WIDTH=2, COMMIT_WIDTH=2, GPR_TAG_WIDTH=6)
REQ-033 After reset, lane0 rs1=5 rs2=0 rd=7 wen, tag 40 -> prs1=5, prs2=0, prd=40, old_prd=7, consume=01.
REQ-034 lane0 rd=3 tag 33, lane1 rs1=3 rd=3 tag 34 -> lane1 prs1=33, old_prd=33; RAT[3]=34; consume=11.
REQ-035 fl_alloc_ready_in=0 with valid group -> dec_ready_out=0, consume=00, RAT unchanged; with macro fl counter +1 per cycle.
REQ-036 ren_ready_in=0 for 3 cycles with valid output -> outputs stable, dec_ready_out=0, no consume.
REQ-037 Rename rd=9->tag 50, commit rd=9 prd=45 with redirect same cycle -> next cycle spec RAT[9]=45, ren_valid_out=0.
REQ-038 Lane with rd=0 wen=1 plus lane rd=4 -> only one tag consumed (consume=01), rd=0 lane prd=0.
